// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement a - b, LSB first, one full-adder cell reused WIDTH times.
// Ports: clk/reset (async, active-high); start with operands a/b; busy/done handshake;
//        registered difference with carryout (1 = no borrow), overflow (signed) and zero flags.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             load;
  logic             last;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             a_msb;
  logic             b_msb;

  logic             bit_a;
  logic             bit_nb;
  logic             sum_bit;
  logic             carry_next;
  logic [WIDTH-1:0] res_next;

  // Subtraction as a + ~b + 1: the +1 comes from the carry being preset on load.
  always_comb begin
    bit_a      = a_sr[0];
    bit_nb     = ~b_sr[0];
    sum_bit    = bit_a ^ bit_nb ^ carry;
    carry_next = (bit_a & bit_nb) | (bit_a & carry) | (bit_nb & carry);
    // Result fills from the top so after WIDTH shifts bit 0 sits in the LSB.
    res_next   = {sum_bit, res_sr[WIDTH-1:1]};
    last       = (cnt == LAST_BIT);
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_RUN;
          load       = 1'b1;
        end
      end
      S_RUN: begin
        if (last) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        // Back-to-back launch straight from DONE keeps a WIDTH+1 cycle period.
        if (start) begin
          state_next = S_RUN;
          load       = 1'b1;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      cnt        <= '0;
      carry      <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      difference <= '0;
      carryout   <= 1'b0;
      overflow   <= 1'b0;
      zero       <= 1'b0;
    end else if (load) begin
      a_sr   <= a;
      b_sr   <= b;
      res_sr <= '0;
      cnt    <= '0;
      carry  <= 1'b1;
      a_msb  <= a[WIDTH-1];
      b_msb  <= b[WIDTH-1];
    end else if (state == S_RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_next;
      carry  <= carry_next;
      cnt    <= cnt + CW'(1);
      if (last) begin
        difference <= res_next;
        carryout   <= carry_next;
        zero       <= (res_next == '0);
        // Signed overflow only possible when operand signs differ and the result sign leaves a's.
        overflow   <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
      end
    end
  end

  // Decoded from the state register only, so still no input-to-output path.
  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule
